// File: rtl/risc_seq_if.sv
// Sequencer-side bundle: IR/flag inputs, run control and the nine control strobes.
// The step input only exists when SINGLE_STEP_EN is defined.
interface risc_seq_if #(
  parameter int OPC_W = 3
);
  logic             enable;
  logic             resume;
  logic             zero;
  logic [OPC_W-1:0] opcode;
`ifdef SINGLE_STEP_EN
  logic             step;
`endif
  logic             sel;
  logic             rd;
  logic             ld_ir;
  logic             inc_pc;
  logic             halt;
  logic             ld_pc;
  logic             data_e;
  logic             ld_ac;
  logic             wr;
  logic [2:0]       phase;
  logic             instr_done;

`ifdef SINGLE_STEP_EN
  modport slave (
    input  enable, resume, zero, opcode, step,
    output sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr, phase, instr_done
  );
  modport master (
    output enable, resume, zero, opcode, step,
    input  sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr, phase, instr_done
  );
`else
  modport slave (
    input  enable, resume, zero, opcode,
    output sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr, phase, instr_done
  );
  modport master (
    output enable, resume, zero, opcode,
    input  sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr, phase, instr_done
  );
`endif
endinterface

// File: rtl/risc_seq_controller.sv
// VeriRISC instruction sequencer: 8-phase counter, HALT state, memory wait stretching.
// Define SINGLE_STEP_EN to gate each instruction start on the step input.
module risc_seq_controller #(
  parameter int OPC_W    = 3,
  parameter int MEM_WAIT = 0,
  parameter int WAIT_W   = 4
) (
  input  logic      clk,
  input  logic      rst,
  risc_seq_if.slave bus
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT);

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  state_t            state_q, state_d;
  logic [2:0]        phase_q, phase_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic             step_ok;
  logic [OPC_W-1:0] opc;
  logic             opc_valid;
  logic [2:0]       opc3;
  logic             is_a, is_h, is_z, is_j, is_s;
  logic             stretch_ph;

  logic sel_c, rd_c, ld_ir_c, inc_pc_c, halt_c, ld_pc_c, data_e_c, ld_ac_c, wr_c;
  logic done_c;

`ifdef SINGLE_STEP_EN
  assign step_ok = bus.step;
`else
  assign step_ok = 1'b1;
`endif

  // Codes above 7 (only possible with OPC_W > 3) decode as NOP.
  assign opc       = bus.opcode;
  assign opc_valid = ((opc >> 3) == '0);
  assign opc3      = opc[2:0];

  assign is_a = opc_valid && ((opc3 == OP_ADD) || (opc3 == OP_AND) ||
                              (opc3 == OP_XOR) || (opc3 == OP_LDA));
  assign is_h = opc_valid && (opc3 == OP_HLT);
  assign is_z = opc_valid && (opc3 == OP_SKZ) && bus.zero;
  assign is_j = opc_valid && (opc3 == OP_JMP);
  assign is_s = opc_valid && (opc3 == OP_STO);

  assign stretch_ph = (phase_q == 3'd1) || (phase_q == 3'd5);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      phase_q <= 3'd0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    wait_d  = wait_q;
    if (bus.enable) begin
      case (state_q)
        ST_RUN: begin
          if (stretch_ph && (wait_q != WAIT_LAST)) begin
            wait_d = wait_q + 1'b1;
          end else begin
            wait_d = '0;
            // HLT parks the sequencer at phase 4 instead of advancing.
            if ((phase_q == 3'd4) && is_h) begin
              state_d = ST_HALTED;
            end else if ((phase_q != 3'd0) || step_ok) begin
              phase_d = phase_q + 3'd1;
            end
          end
        end
        ST_HALTED: begin
          if (bus.resume) begin
            state_d = ST_RUN;
            phase_d = 3'd5;
            wait_d  = '0;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    sel_c    = 1'b0;
    rd_c     = 1'b0;
    ld_ir_c  = 1'b0;
    inc_pc_c = 1'b0;
    halt_c   = 1'b0;
    ld_pc_c  = 1'b0;
    data_e_c = 1'b0;
    ld_ac_c  = 1'b0;
    wr_c     = 1'b0;
    done_c   = 1'b0;
    if (state_q == ST_HALTED) begin
      halt_c = 1'b1;
    end else begin
      case (phase_q)
        3'd0: sel_c = 1'b1;
        3'd1: begin
          sel_c = 1'b1;
          rd_c  = 1'b1;
        end
        3'd2, 3'd3: begin
          sel_c   = 1'b1;
          rd_c    = 1'b1;
          ld_ir_c = 1'b1;
        end
        3'd4: begin
          inc_pc_c = 1'b1;
          halt_c   = is_h;
        end
        3'd5: rd_c = is_a;
        3'd6: begin
          rd_c     = is_a;
          inc_pc_c = is_z;
          ld_pc_c  = is_j;
          data_e_c = is_s;
        end
        default: begin
          rd_c     = is_a;
          ld_pc_c  = is_j;
          data_e_c = is_s;
          ld_ac_c  = is_a;
          wr_c     = is_s;
        end
      endcase
      // Phase 7 is never stretched, so its only cycle is the exit cycle.
      done_c = bus.enable && (phase_q == 3'd7);
    end
  end

  assign bus.sel        = sel_c;
  assign bus.rd         = rd_c;
  assign bus.ld_ir      = ld_ir_c;
  assign bus.inc_pc     = inc_pc_c;
  assign bus.halt       = halt_c;
  assign bus.ld_pc      = ld_pc_c;
  assign bus.data_e     = data_e_c;
  assign bus.ld_ac      = ld_ac_c;
  assign bus.wr         = wr_c;
  assign bus.phase      = phase_q;
  assign bus.instr_done = done_c;

endmodule

// File: tb/tb_risc_seq_controller.sv
// Scoreboard bench for risc_seq_controller: three configurations driven by directed vectors.
// Strobe vectors are {sel,rd,ld_ir,inc_pc,halt,ld_pc,data_e,ld_ac,wr}.
module tb_risc_seq_controller;

  logic clk;
  logic rst;

  localparam logic [8:0] S_PH0   = 9'b100000000;
  localparam logic [8:0] S_PH1   = 9'b110000000;
  localparam logic [8:0] S_FETCH = 9'b111000000;
  localparam logic [8:0] S_INC   = 9'b000100000;
  localparam logic [8:0] S_HLT4  = 9'b000110000;
  localparam logic [8:0] S_HALT  = 9'b000010000;
  localparam logic [8:0] S_RD    = 9'b010000000;
  localparam logic [8:0] S_RDAC  = 9'b010000010;
  localparam logic [8:0] S_STO6  = 9'b000000100;
  localparam logic [8:0] S_STO7  = 9'b000000101;
  localparam logic [8:0] S_NONE  = 9'b000000000;

  typedef struct packed {
    logic [2:0]  dut;
    logic [15:0] tag;
    logic [12:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cyc_n        = 0;

  risc_seq_if #(.OPC_W(3)) if0 ();
  risc_seq_if #(.OPC_W(3)) if2 ();
  risc_seq_if #(.OPC_W(4)) if4 ();

  risc_seq_controller #(.OPC_W(3), .MEM_WAIT(0), .WAIT_W(4)) u0 (.clk(clk), .rst(rst), .bus(if0));
  risc_seq_controller #(.OPC_W(3), .MEM_WAIT(2), .WAIT_W(4)) u2 (.clk(clk), .rst(rst), .bus(if2));
  risc_seq_controller #(.OPC_W(4), .MEM_WAIT(0), .WAIT_W(4)) u4 (.clk(clk), .rst(rst), .bus(if4));

  logic [12:0] act0, act2, act4;
  assign act0 = {if0.phase, if0.sel, if0.rd, if0.ld_ir, if0.inc_pc, if0.halt,
                 if0.ld_pc, if0.data_e, if0.ld_ac, if0.wr, if0.instr_done};
  assign act2 = {if2.phase, if2.sel, if2.rd, if2.ld_ir, if2.inc_pc, if2.halt,
                 if2.ld_pc, if2.data_e, if2.ld_ac, if2.wr, if2.instr_done};
  assign act4 = {if4.phase, if4.sel, if4.rd, if4.ld_ir, if4.inc_pc, if4.halt,
                 if4.ld_pc, if4.data_e, if4.ld_ac, if4.wr, if4.instr_done};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: one expected record per cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [12:0] a;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      case (e.dut)
        3'd2:    a = act2;
        3'd4:    a = act4;
        default: a = act0;
      endcase
      tests_run++;
      if (a !== e.exp) begin
        tests_failed++;
        $display("FAIL dut%0d t%0d c%0d: got ph=%0d strb=%b done=%b, expected ph=%0d strb=%b done=%b",
                 e.dut, e.tag[15:12], e.tag[11:0], a[12:10], a[9:1], a[0],
                 e.exp[12:10], e.exp[9:1], e.exp[0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input int d, input int t, input logic [2:0] ph,
                     input logic [8:0] st, input logic dn);
    exp_t e;
    e.dut = 3'(d);
    e.tag = {4'(t), 12'(cyc_n)};
    e.exp = {ph, st, dn};
    sbq.push_back(e);
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic select(input int d);
    if0.enable = (d == 0);
    if2.enable = (d == 2);
    if4.enable = (d == 4);
  endtask

  task automatic rst_pulse(input int d, input int t);
    rst = 1'b1;
    chk(d, t, 3'd0, S_PH0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic fetch0(input int d, input int t);
    chk(d, t, 3'd0, S_PH0, 1'b0);
    chk(d, t, 3'd1, S_PH1, 1'b0);
    chk(d, t, 3'd2, S_FETCH, 1'b0);
    chk(d, t, 3'd3, S_FETCH, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    if0.resume = 1'b0; if0.zero = 1'b0; if0.opcode = 3'd0;
    if2.resume = 1'b0; if2.zero = 1'b0; if2.opcode = 3'd0;
    if4.resume = 1'b0; if4.zero = 1'b0; if4.opcode = 4'd0;
`ifdef SINGLE_STEP_EN
    if0.step = 1'b1; if2.step = 1'b1; if4.step = 1'b1;
`endif
    select(0);
    @(posedge clk);
    #1;

    // 1: LDA, no wait states
    if0.opcode = 3'd5;
    rst_pulse(0, 1);
    fetch0(0, 1);
    chk(0, 1, 3'd4, S_INC, 1'b0);
    chk(0, 1, 3'd5, S_RD, 1'b0);
    chk(0, 1, 3'd6, S_RD, 1'b0);
    chk(0, 1, 3'd7, S_RDAC, 1'b1);
    chk(0, 1, 3'd0, S_PH0, 1'b0);

    // 2: STO with two wait states
    select(2);
    if2.opcode = 3'd6;
    rst_pulse(2, 2);
    chk(2, 2, 3'd0, S_PH0, 1'b0);
    for (int i = 0; i < 3; i++) chk(2, 2, 3'd1, S_PH1, 1'b0);
    chk(2, 2, 3'd2, S_FETCH, 1'b0);
    chk(2, 2, 3'd3, S_FETCH, 1'b0);
    chk(2, 2, 3'd4, S_INC, 1'b0);
    for (int i = 0; i < 3; i++) chk(2, 2, 3'd5, S_NONE, 1'b0);
    chk(2, 2, 3'd6, S_STO6, 1'b0);
    chk(2, 2, 3'd7, S_STO7, 1'b1);
    chk(2, 2, 3'd0, S_PH0, 1'b0);

    // 3: HLT, 20 halted cycles, then resume
    select(0);
    if0.opcode = 3'd0;
    rst_pulse(0, 3);
    fetch0(0, 3);
    chk(0, 3, 3'd4, S_HLT4, 1'b0);
    for (int i = 0; i < 20; i++) chk(0, 3, 3'd4, S_HALT, 1'b0);
    if0.resume = 1'b1;
    chk(0, 3, 3'd4, S_HALT, 1'b0);
    if0.resume = 1'b0;
    chk(0, 3, 3'd5, S_NONE, 1'b0);
    chk(0, 3, 3'd6, S_NONE, 1'b0);
    chk(0, 3, 3'd7, S_NONE, 1'b1);
    chk(0, 3, 3'd0, S_PH0, 1'b0);

    // 4: SKZ with zero=1 then zero=0; resume held high in RUN must do nothing
    if0.opcode = 3'd1;
    if0.zero   = 1'b1;
    if0.resume = 1'b1;
    rst_pulse(0, 4);
    fetch0(0, 4);
    chk(0, 4, 3'd4, S_INC, 1'b0);
    chk(0, 4, 3'd5, S_NONE, 1'b0);
    chk(0, 4, 3'd6, S_INC, 1'b0);
    chk(0, 4, 3'd7, S_NONE, 1'b1);
    if0.zero   = 1'b0;
    if0.resume = 1'b0;
    fetch0(0, 4);
    chk(0, 4, 3'd4, S_INC, 1'b0);
    chk(0, 4, 3'd5, S_NONE, 1'b0);
    chk(0, 4, 3'd6, S_NONE, 1'b0);
    chk(0, 4, 3'd7, S_NONE, 1'b1);

    // 4b: opcode 9 on a 4-bit field is a NOP even though its low bits alias SKZ
    select(4);
    if4.opcode = 4'd9;
    if4.zero   = 1'b1;
    rst_pulse(4, 4);
    fetch0(4, 4);
    chk(4, 4, 3'd4, S_INC, 1'b0);
    chk(4, 4, 3'd5, S_NONE, 1'b0);
    chk(4, 4, 3'd6, S_NONE, 1'b0);
    chk(4, 4, 3'd7, S_NONE, 1'b1);

    // 5: reset mid-instruction, then enable stalls at ph3 and ph7
    select(0);
    if0.opcode = 3'd2;
    rst_pulse(0, 5);
    fetch0(0, 5);
    chk(0, 5, 3'd4, S_INC, 1'b0);
    rst = 1'b1;
    chk(0, 5, 3'd0, S_PH0, 1'b0);
    rst = 1'b0;
    chk(0, 5, 3'd0, S_PH0, 1'b0);
    chk(0, 5, 3'd1, S_PH1, 1'b0);
    chk(0, 5, 3'd2, S_FETCH, 1'b0);
    if0.enable = 1'b0;
    for (int i = 0; i < 5; i++) chk(0, 5, 3'd3, S_FETCH, 1'b0);
    if0.enable = 1'b1;
    chk(0, 5, 3'd3, S_FETCH, 1'b0);
    chk(0, 5, 3'd4, S_INC, 1'b0);
    chk(0, 5, 3'd5, S_RD, 1'b0);
    chk(0, 5, 3'd6, S_RD, 1'b0);
    if0.enable = 1'b0;
    chk(0, 5, 3'd7, S_RDAC, 1'b0);
    if0.enable = 1'b1;
    chk(0, 5, 3'd7, S_RDAC, 1'b1);
    chk(0, 5, 3'd0, S_PH0, 1'b0);

`ifdef SINGLE_STEP_EN
    // 6: single-step gating of phase 0
    if0.opcode = 3'd5;
    if0.step   = 1'b0;
    rst_pulse(0, 6);
    for (int i = 0; i < 10; i++) chk(0, 6, 3'd0, S_PH0, 1'b0);
    if0.step = 1'b1;
    chk(0, 6, 3'd0, S_PH0, 1'b0);
    if0.step = 1'b0;
    chk(0, 6, 3'd1, S_PH1, 1'b0);
    chk(0, 6, 3'd2, S_FETCH, 1'b0);
    chk(0, 6, 3'd3, S_FETCH, 1'b0);
    chk(0, 6, 3'd4, S_INC, 1'b0);
    chk(0, 6, 3'd5, S_RD, 1'b0);
    chk(0, 6, 3'd6, S_RD, 1'b0);
    chk(0, 6, 3'd7, S_RDAC, 1'b1);
    for (int i = 0; i < 3; i++) chk(0, 6, 3'd0, S_PH0, 1'b0);
    if0.step = 1'b1;
    chk(0, 6, 3'd0, S_PH0, 1'b0);
    if0.step = 1'b0;
    chk(0, 6, 3'd1, S_PH1, 1'b0);
`endif

    @(posedge clk);
    #1;
    tests_run++;
    if (sbq.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
